// File: rtl/uart_receiver.sv
// UART receiver: 2-flop input synchroniser, mid-bit sampling FSM and a
// valid/ready holding register. Error conditions leave as one-cycle pulses.
module uart_receiver #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_BITS    = 8,
   parameter bit          PARITY_EN    = 1'b0,
   parameter bit          PARITY_ODD   = 1'b0
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic                 busy_o,
   output logic                 frame_err_o,
   output logic                 parity_err_o,
   output logic                 overrun_o
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e               state_q;
   logic [CNT_W-1:0]     bit_cnt_q;
   logic [IDX_W-1:0]     idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic                 frame_err_q;
   logic                 parity_err_q;
   logic                 overrun_q;

   logic                 rx_meta_q;
   logic                 rx_s_q;
   logic                 rx_prev_q;

   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;

   logic                 fall_edge;
   logic                 bit_done;
   logic                 frame_end;
   logic                 parity_bad;
   logic                 word_good;

   // Bring rx_i into the clock domain; idle-high reset so no false edge after reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
      end
   end

   // Frame-level decode of the current cycle; parity_bad is 1 when the received
   // parity bit differs from XOR(data) ^ PARITY_ODD
   always_comb begin
      fall_edge  = rx_prev_q & ~rx_s_q;
      bit_done   = (bit_cnt_q == BIT_LAST);
      frame_end  = (state_q == S_STOP) && bit_done;
      parity_bad = PARITY_EN & (par_q ^ (^shift_q) ^ PARITY_ODD);
      word_good  = frame_end & rx_s_q & ~parity_bad;
   end

   // Receive FSM: start qualification at half-bit, then one sample per bit period;
   // the error pulses are registered one cycle after the stop sample
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         idx_q        <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         frame_err_q  <= frame_end & ~rx_s_q;
         parity_err_q <= frame_end & parity_bad;
         overrun_q    <= word_good & valid_q & ~ready_i;
         case (state_q)
            S_IDLE: begin
               if (fall_edge) begin
                  state_q   <= S_START;
                  bit_cnt_q <= '0;
               end
            end
            S_START: begin
               if (bit_cnt_q == HALF_LAST) begin
                  bit_cnt_q <= '0;
                  idx_q     <= '0;
                  state_q   <= rx_s_q ? S_IDLE : S_DATA;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (bit_done) begin
                  bit_cnt_q <= '0;
                  shift_q   <= {rx_s_q, shift_q[DATA_BITS-1:1]};
                  idx_q     <= idx_q + 1'b1;
                  if (idx_q == IDX_LAST) begin
                     state_q <= PARITY_EN ? S_PARITY : S_STOP;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            S_PARITY: begin
               if (bit_done) begin
                  bit_cnt_q <= '0;
                  par_q     <= rx_s_q;
                  state_q   <= S_STOP;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               // Leave at mid-stop so a back-to-back start edge is not missed
               if (bit_done) begin
                  bit_cnt_q <= '0;
                  state_q   <= S_IDLE;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q   <= S_IDLE;
               bit_cnt_q <= '0;
            end
         endcase
      end
   end

   // Holding register next state: load a good word when free or being drained, else clear on handshake
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (word_good && (!valid_q || ready_i)) begin
         data_d  = shift_q;
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Holding register state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o       = data_q;
   assign valid_o      = valid_q;
   assign busy_o       = (state_q != S_IDLE);
   assign frame_err_o  = frame_err_q;
   assign parity_err_o = parity_err_q;
   assign overrun_o    = overrun_q;

endmodule
